// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one unified memory port between the D-cache and I-cache miss paths.
// Define ARB_STATS_EN to add saturating grant counters and a contention counter.
module unified_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W:0]   mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       d_grant_count,
  output logic [15:0]       i_grant_count,
  output logic [15:0]       contention_count
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_D = 3'd1,
    GRANT_I = 3'd2,
    DONE_D  = 3'd3,
    DONE_I  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant_i;
  logic                r_started;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W:0]     r_mem_address;
  logic [DATA_W-1:0]   r_mem_writedata;
  logic [DATA_W-1:0]   r_d_readdata;
  logic [DATA_W-1:0]   r_i_readdata;

  logic                w_d_req;
  logic                w_i_req;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_complete;
  logic                w_in_grant;

  assign w_d_req    = d_read | d_write;
  assign w_i_req    = i_read;
  assign w_in_grant = (r_state == GRANT_D) || (r_state == GRANT_I);

  assign d_busywait    = w_d_req & (r_state != DONE_D);
  assign i_busywait    = w_i_req & (r_state != DONE_I);
  assign d_readdata    = r_d_readdata;
  assign i_readdata    = r_i_readdata;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;

  // A tie goes to whichever side was not granted last.
  always_comb begin
    w_next     = r_state;
    w_grant_d  = 1'b0;
    w_grant_i  = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!w_i_req || r_last_grant_i)) begin
          w_grant_d = 1'b1;
          w_next    = GRANT_D;
        end else if (w_i_req) begin
          w_grant_i = 1'b1;
          w_next    = GRANT_I;
        end
      end
      GRANT_D: begin
        if (r_started && !mem_busywait) begin
          w_complete = 1'b1;
          w_next     = DONE_D;
        end
      end
      GRANT_I: begin
        if (r_started && !mem_busywait) begin
          w_complete = 1'b1;
          w_next     = DONE_I;
        end
      end
      DONE_D, DONE_I: w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state         <= IDLE;
      r_last_grant_i  <= 1'b1;
      r_started       <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_d_readdata    <= '0;
      r_i_readdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_d) begin
        r_mem_address   <= {1'b0, d_address};
        r_mem_writedata <= d_writedata;
        r_mem_write     <= d_write;
        r_mem_read      <= d_read & ~d_write;
        r_last_grant_i  <= 1'b0;
        r_started       <= 1'b0;
      end
      if (w_grant_i) begin
        r_mem_address  <= {1'b1, i_address};
        r_mem_write    <= 1'b0;
        r_mem_read     <= 1'b1;
        r_last_grant_i <= 1'b1;
        r_started      <= 1'b0;
      end
      // The memory must first be seen busy so a stale idle level is not taken as completion.
      if (w_in_grant && mem_busywait) begin
        r_started <= 1'b1;
      end
      if (w_complete) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (r_state == GRANT_I) begin
          r_i_readdata <= mem_readdata;
        end else if (r_mem_read) begin
          r_d_readdata <= mem_readdata;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_d_grant_count;
  logic [15:0] r_i_grant_count;
  logic [15:0] r_contention_count;

  assign d_grant_count    = r_d_grant_count;
  assign i_grant_count    = r_i_grant_count;
  assign contention_count = r_contention_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_d_grant_count    <= '0;
      r_i_grant_count    <= '0;
      r_contention_count <= '0;
    end else begin
      if (r_state == DONE_D) begin
        r_d_grant_count <= sat_inc16(r_d_grant_count);
      end
      if (r_state == DONE_I) begin
        r_i_grant_count <= sat_inc16(r_i_grant_count);
      end
      if ((r_state == IDLE) && w_d_req && w_i_req) begin
        r_contention_count <= r_contention_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a latency-programmable memory peer plus cache-side request tasks
// checked against a flat reference image of unified memory.
module tb_unified_mem_arbiter;
  localparam int TMO = 300;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        d_read, d_write;
  logic [5:0]  d_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        i_read;
  logic [5:0]  i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        mem_read, mem_write;
  logic [6:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef ARB_STATS_EN
  logic [15:0] d_grant_count, i_grant_count, contention_count;
`endif

  unified_mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef ARB_STATS_EN
    , .d_grant_count(d_grant_count), .i_grant_count(i_grant_count),
    .contention_count(contention_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_val(input logic [6:0] a);
    return {(a[6] ? 16'hBEEF : 16'hCAFE), 9'd0, a};
  endfunction

  // Memory peer: busy for mem_lat cycles per transaction, re-arms only after strobes drop.
  bit   [31:0] mem_arr [128];
  bit   [127:0] mem_valid;
  bit          m_busy, m_wait;
  bit   [31:0] m_rdata;
  int          m_cnt;
  logic [6:0]  m_addr;
  logic        m_rd, m_wr;
  logic [31:0] m_wd;
  int          mem_lat;
  int          stab_viol, excl_viol;
  logic [6:0]  log_addr [$];
  logic        log_rd [$];
  logic        log_wr [$];
  logic [31:0] log_wd [$];

  assign mem_busywait = m_busy;
  assign mem_readdata = m_rdata;

  always @(posedge CLK) begin
    if (RESET) begin
      m_busy <= 1'b0;
      m_wait <= 1'b0;
    end else if (m_busy) begin
      if (mem_address !== m_addr || mem_read !== m_rd || mem_write !== m_wr ||
          (m_wr && mem_writedata !== m_wd))
        stab_viol <= stab_viol + 1;
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        m_wait <= 1'b1;
        if (m_wr) begin
          mem_arr[m_addr]   <= m_wd;
          mem_valid[m_addr] <= 1'b1;
        end else begin
          m_rdata <= mem_valid[m_addr] ? mem_arr[m_addr] : init_val(m_addr);
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_wait) begin
      if (!mem_read && !mem_write) m_wait <= 1'b0;
    end else if (mem_read || mem_write) begin
      m_busy <= 1'b1;
      m_cnt  <= mem_lat;
      m_addr <= mem_address;
      m_rd   <= mem_read;
      m_wr   <= mem_write;
      m_wd   <= mem_writedata;
      if (mem_read && mem_write) stab_viol <= stab_viol + 1;
      log_addr.push_back(mem_address);
      log_rd.push_back(mem_read);
      log_wr.push_back(mem_write);
      log_wd.push_back(mem_writedata);
    end
  end

  always @(negedge CLK) begin
    if ((d_read || d_write) && !d_busywait && i_read && !i_busywait)
      excl_viol <= excl_viol + 1;
  end

  int          checks, errors;
  logic [31:0] ref_mem [128];
  logic [31:0] exp_d;
  int          n_d, n_i;
  time         t_d, t_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_d(input logic rd, input logic wr, input logic [5:0] a,
                      input logic [31:0] wd, input bit chk_stall);
    int cyc;
    @(negedge CLK);
    d_read = rd; d_write = wr; d_address = a; d_writedata = wd;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (d_busywait === 1'b1 && cyc < TMO);
    check("d_timeout", d_busywait, 0);
    if (wr) ref_mem[{1'b0, a}] = wd;
    else    exp_d = ref_mem[{1'b0, a}];
    check("d_readdata", d_readdata, exp_d);
    if (chk_stall) check("d_stall", cyc, mem_lat + 3);
    d_read = 1'b0; d_write = 1'b0;
    t_d = $time; n_d++;
  endtask

  task automatic do_i(input logic [5:0] a, input bit chk_stall);
    int cyc;
    @(negedge CLK);
    i_read = 1'b1; i_address = a;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (i_busywait === 1'b1 && cyc < TMO);
    check("i_timeout", i_busywait, 0);
    check("i_readdata", i_readdata, ref_mem[{1'b1, a}]);
    if (chk_stall) check("i_stall", cyc, mem_lat + 3);
    i_read = 1'b0;
    t_i = $time; n_i++;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_d = '0; n_d = 0; n_i = 0;
  endtask

  int          base, mode, opsel, sd, si;
  logic [5:0]  da, ia;
  logic [31:0] wd;
  logic        rd, wr;

  initial begin
    RESET = 1'b1; d_read = 0; d_write = 0; d_address = '0; d_writedata = '0;
    i_read = 0; i_address = '0; mem_lat = 5; checks = 0; errors = 0;
    exp_d = '0; n_d = 0; n_i = 0; t_d = 0; t_i = 0;
    for (int a = 0; a < 128; a++) ref_mem[a] = init_val(7'(a));
    repeat (3) @(negedge CLK);

    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_writedata", mem_writedata, 0);
    check("rst_d_readdata", d_readdata, 0);
    check("rst_i_readdata", i_readdata, 0);
    check("rst_d_busywait", d_busywait, 0);
    check("rst_i_busywait", i_busywait, 0);
    RESET = 1'b0;

    // Data read alone, 5 busy cycles
    base = log_addr.size();
    do_d(1'b1, 1'b0, 6'h05, 32'h0, 1'b1);
    check("dread_val", d_readdata, 32'hCAFE0005);
    check("dread_nlog", log_addr.size() - base, 1);
    check("dread_addr", log_addr[base], 7'h05);
    check("dread_rd", log_rd[base], 1);
    check("dread_wr", log_wr[base], 0);
    check("dread_i_bw", i_busywait, 0);

    // Instruction read alone
    base = log_addr.size();
    do_i(6'h03, 1'b1);
    check("iread_addr", log_addr[base], 7'h43);
    check("iread_rd", log_rd[base], 1);
    check("iread_wr", log_wr[base], 0);

    // Two contention rounds after reset: D, I, D, I
    pulse_reset();
    base = log_addr.size();
    for (int r = 0; r < 2; r++) begin
      da = 6'($urandom); ia = 6'($urandom);
      fork
        do_d(1'b1, 1'b0, da, 32'h0, 1'b0);
        do_i(ia, 1'b0);
      join
      check("rr_d_before_i", (t_d < t_i), 1);
    end
    check("rr_nlog", log_addr.size() - base, 4);
    check("rr_0_data", log_addr[base][6], 0);
    check("rr_1_instr", log_addr[base+1][6], 1);
    check("rr_2_data", log_addr[base+2][6], 0);
    check("rr_3_instr", log_addr[base+3][6], 1);

    // Write-back with both strobes requested: write wins, readdata untouched
    da = 6'($urandom);
    base = log_addr.size();
    do_d(1'b1, 1'b1, da, 32'h12345678, 1'b1);
    check("wb_wr", log_wr[base], 1);
    check("wb_rd", log_rd[base], 0);
    check("wb_wdata", log_wd[base], 32'h12345678);
    check("wb_addr", log_addr[base], {1'b0, da});
    do_d(1'b1, 1'b0, da, 32'h0, 1'b1);
    check("wb_readback", d_readdata, 32'h12345678);
`ifdef ARB_STATS_EN
    check("stat_d", d_grant_count, 16'(n_d));
    check("stat_i", i_grant_count, 16'(n_i));
    check("stat_cont", contention_count, 2);
`endif

    // Reset pulse while the instruction side is being served
    mem_lat = 5;
    @(negedge CLK);
    i_read = 1'b1; i_address = 6'h2A;
    repeat (3) @(negedge CLK);
    check("gi_busy", i_busywait, 1);
    check("gi_mem_read", mem_read, 1);
    RESET = 1'b1;
    @(negedge CLK);
    check("rsti_mem_read", mem_read, 0);
    check("rsti_mem_write", mem_write, 0);
    check("rsti_i_busywait", i_busywait, 1);
    check("rsti_i_readdata", i_readdata, 0);
`ifdef ARB_STATS_EN
    check("rsti_stat_d", d_grant_count, 0);
    check("rsti_stat_i", i_grant_count, 0);
    check("rsti_stat_c", contention_count, 0);
`endif
    RESET = 1'b0; i_read = 1'b0;
    exp_d = '0; n_d = 0; n_i = 0;
    do_i(6'h2A, 1'b1);
`ifdef ARB_STATS_EN
    check("post_rst_stat_i", i_grant_count, 1);
`endif

    // Randomised traffic against the reference image
    for (int it = 0; it < 40; it++) begin
      mode    = int'($urandom_range(0, 2));
      mem_lat = int'($urandom_range(1, 6));
      opsel   = int'($urandom_range(0, 2));
      rd = (opsel != 1); wr = (opsel != 0);
      da = 6'($urandom); ia = 6'($urandom); wd = $urandom;
      sd = int'($urandom_range(0, 3)); si = int'($urandom_range(0, 3));
      case (mode)
        0: do_d(rd, wr, da, wd, 1'b1);
        1: do_i(ia, 1'b1);
        default: fork
          begin repeat (sd) @(negedge CLK); do_d(rd, wr, da, wd, 1'b0); end
          begin repeat (si) @(negedge CLK); do_i(ia, 1'b0); end
        join
      endcase
    end

    repeat (3) @(negedge CLK);
    check("strobe_stability", stab_viol, 0);
    check("single_done", excl_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one unified main memory port between the data cache miss path and the instruction cache miss path.
- Replaces the separate data and instruction memories: both caches connect to this block, and this block drives the single memory.
- Data blocks occupy the lower half of unified memory and instruction blocks the upper half, selected by the address MSB.
- Arbitration is round-robin; the block runs one memory transaction at a time and stalls the losing requester via its busywait.

Parameters:
- ADDR_W, 6, block address width of each cache-side request.
- DATA_W, 32, block data width (both requesters and memory use this width).

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- d_read  input  1  data cache block read request
- d_write  input  1  data cache block write-back request
- d_address  input  ADDR_W  data cache block address
- d_writedata  input  DATA_W  data cache write-back block
- d_readdata  output  DATA_W  block returned to data cache
- d_busywait  output  1  stall to data cache
- i_read  input  1  instruction cache block read request
- i_address  input  ADDR_W  instruction cache block address
- i_readdata  output  DATA_W  block returned to instruction cache
- i_busywait  output  1  stall to instruction cache
- mem_read  output  1  unified memory read strobe
- mem_write  output  1  unified memory write strobe
- mem_address  output  ADDR_W+1  unified address {region, block}; region 0 = data, 1 = instruction
- mem_writedata  output  DATA_W  write block to memory
- mem_readdata  input  DATA_W  block from memory
- mem_busywait  input  1  memory busy

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET).
- Reset values:
  - state = IDLE; last_grant = I, so data wins the first tie.
  - mem_read, mem_write, mem_address, mem_writedata = 0.
  - d_readdata, i_readdata = 0; started = 0.
- Requests:
  - d_req = d_read | d_write; i_req = i_read.
  - If d_read and d_write are both asserted, the write is performed.
- Busywait outputs (combinational):
  - d_busywait = d_req & !(state == DONE_D).
  - i_busywait = i_req & !(state == DONE_I).
  - A request is therefore stalled from the cycle it appears until its DONE cycle.
- State IDLE:
  - Only d_req → GRANT_D.
  - Only i_req → GRANT_I.
  - Both → grant the side opposite last_grant.
  - Neither → stay in IDLE.
  - On grant, register the memory drive for the next cycle:
    - data: mem_address = {1'b0, d_address}, mem_writedata = d_writedata, mem_write = d_write, mem_read = d_read & !d_write.
    - instruction: mem_address = {1'b1, i_address}, mem_read = 1.
  - Update last_grant and clear started.
- States GRANT_D / GRANT_I:
  - Hold all mem_* outputs stable.
  - Set started when mem_busywait = 1 is sampled.
  - When started = 1 and mem_busywait = 0 is sampled:
    - latch mem_readdata into d_readdata or i_readdata (write-only transactions leave d_readdata unchanged);
    - clear mem_read and mem_write;
    - go to DONE_D / DONE_I.
- States DONE_D / DONE_I:
  - Exactly one cycle; the granted requester's busywait is low.
  - Always return to IDLE. The requester drops its request at that edge, so it is not re-granted.
- Latency: grant edge +1 to memory strobe; memory latency N busy cycles; +1 DONE cycle. Minimum requester stall = N+3 cycles.
- A request arriving while the other side is being served waits, with busywait high, until IDLE.
- RESET asserted mid-transaction:
  - Aborts the transaction and clears the strobes at that edge.
  - Both DONE states are left, so busywait re-follows the requests.
- Readdata registers hold their value until overwritten by the next completion on the same side.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, the block adds:
  - outputs d_grant_count[15:0] and i_grant_count[15:0], incremented on each DONE_D / DONE_I cycle; they saturate at 16'hFFFF;
  - output contention_count[15:0], incremented whenever IDLE sees d_req and i_req together;
  - all three counters reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Data read alone: d_read=1, d_address=6'h05, memory busy 5 cycles returning 32'hCAFE0005 → mem_address=7'h05 and mem_read=1; d_readdata=32'hCAFE0005 in DONE_D; d_busywait low for one cycle; i_busywait stays 0.
- Instruction read alone: i_read=1, i_address=6'h03 → mem_address=7'h43, mem_write=0; i_readdata is the returned block.
- Simultaneous requests after reset: d_read and i_read rise on the same cycle → data served first; i_busywait stays high throughout; instruction served next with mem_address MSB=1.
- Back-to-back contention twice: grant order is D, I, D, I (round-robin).
- Write-back with d_read=d_write=1, d_writedata=32'h12345678 → mem_write=1, mem_read=0, mem_writedata=32'h12345678; d_readdata unchanged.
- RESET pulse during GRANT_I → at the next edge mem_read=0 and state is IDLE; a re-asserted i_read is served normally. With ARB_STATS_EN, all counters return to 0.
